bouncy: RTL and testbench

BOUNCY -- requirements
Module: bouncy

---
 rtl/bouncy.sv | 89 ++++++++
 tb/tb_bouncy.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bouncy.sv
// Bouncing point generator for a small pixel display.
// A free-running divider produces a movement tick every CLK_DIV clocks; on each
// tick the point steps one pixel diagonally and reflects off the display edges.
// Each axis reflects on its own, so hitting a corner reverses both directions.
module bouncy #(
  parameter int CLK_DIV = 1000000,
  parameter int X_MAX   = 95,
  parameter int Y_MAX   = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [6:0] bouncy_x,
  output logic [5:0] bouncy_y
);

  // A divide-by-one still needs a one-bit counter; it simply stays at zero.
  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [6:0]       X_LIM    = 7'(X_MAX);
  localparam logic [5:0]       Y_LIM    = 6'(Y_MAX);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             dir_x;
  logic             dir_y;

  assign tick = (tick_cnt == CNT_LAST);

  // Movement divider: counts 0..CLK_DIV-1, the last count is the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // X axis: step toward the current direction, reflect at 0 and X_MAX.
  // The limit tests use >= / == 0 so the register can never step past an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bouncy_x <= 7'd0;
      dir_x    <= 1'b1;
    end else if (tick) begin
      if (dir_x) begin
        if (bouncy_x >= X_LIM) begin
          bouncy_x <= X_LIM - 7'd1;
          dir_x    <= 1'b0;
        end else begin
          bouncy_x <= bouncy_x + 7'd1;
        end
      end else begin
        if (bouncy_x == 7'd0) begin
          bouncy_x <= 7'd1;
          dir_x    <= 1'b1;
        end else begin
          bouncy_x <= bouncy_x - 7'd1;
        end
      end
    end
  end

  // Y axis: same reflection rule as X, bounded by Y_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bouncy_y <= 6'd0;
      dir_y    <= 1'b1;
    end else if (tick) begin
      if (dir_y) begin
        if (bouncy_y >= Y_LIM) begin
          bouncy_y <= Y_LIM - 6'd1;
          dir_y    <= 1'b0;
        end else begin
          bouncy_y <= bouncy_y + 6'd1;
        end
      end else begin
        if (bouncy_y == 6'd0) begin
          bouncy_y <= 6'd1;
          dir_y    <= 1'b1;
        end else begin
          bouncy_y <= bouncy_y - 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bouncy.sv
// Bench for the bouncing point generator.
// Three instances share one clock and one reset:
//   dut_a: default display, divide-by-4
//   dut_b: 8x8 display, divide-by-1 (tick on every edge)
//   dut_c: default display, long divider
// Expected positions come from a closed-form triangle-wave model and from
// fixed coordinates; they are queued before each edge and popped after it.
`timescale 1ns/1ps
module tb_bouncy;

  localparam int LONG_DIV = 40000;

  logic       clk     = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n   = 1'b0;
  logic [6:0] ax, bx, cx;
  logic [5:0] ay, by, cy;

  typedef struct {
    int x;
    int y;
  } pos_t;

  pos_t sb[$];
  pos_t exp_p;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   edges        = 0;

  bouncy #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bouncy_x(ax), .bouncy_y(ay)
  );
  bouncy #(.CLK_DIV(1), .X_MAX(7), .Y_MAX(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .bouncy_x(bx), .bouncy_y(by)
  );
  bouncy #(.CLK_DIV(LONG_DIV)) dut_c (
    .clk(clk), .rst_n(rst_n), .bouncy_x(cx), .bouncy_y(cy)
  );

  // Gated 10 ns clock so the reset test can hold the clock still.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Position after n ticks: a triangle wave of period 2*m.
  function automatic int tri_pos(int n, int m);
    int p;
    p = n % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Reset pulse of 3 ns placed between clock edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    edges = 0;
  endtask

  task automatic test_reset();
    clk_run = 1'b0;
    rst_n   = 1'b0;
    #3;
    tests_run++;
    if (ax !== 7'd0 || ay !== 6'd0 || bx !== 7'd0 || by !== 6'd0 || cx !== 7'd0 || cy !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_no_clock: got a(%0d,%0d) b(%0d,%0d) c(%0d,%0d) expected all (0,0)",
               ax, ay, bx, by, cx, cy);
    end
    rst_n = 1'b1;
    #1 clk_run = 1'b1;
    edges = 0;
    for (int e = 1; e <= 8; e++) begin
      sb.push_back('{tri_pos(e / 4, 95), tri_pos(e / 4, 63)});
      advance();
      exp_p = sb.pop_front();
      tests_run++;
      if (ax !== 7'(exp_p.x) || ay !== 6'(exp_p.y)) begin
        tests_failed++;
        $display("FAIL reset_release_edge%0d: got (%0d,%0d) expected (%0d,%0d)",
                 e, ax, ay, exp_p.x, exp_p.y);
      end
      if (e == 3 || e == 4 || e == 8) begin
        tests_run++;
        if ((e == 3 && (ax !== 7'd0 || ay !== 6'd0)) ||
            (e == 4 && (ax !== 7'd1 || ay !== 6'd1)) ||
            (e == 8 && (ax !== 7'd2 || ay !== 6'd2))) begin
          tests_failed++;
          $display("FAIL first_ticks_edge%0d: got (%0d,%0d) expected (%0d,%0d)",
                   e, ax, ay, e / 4, e / 4);
        end
      end
    end
  endtask

  task automatic test_bounce_y();
    while (edges < 4 * 64) begin
      sb.push_back('{tri_pos((edges + 1) / 4, 95), tri_pos((edges + 1) / 4, 63)});
      advance();
      exp_p = sb.pop_front();
      tests_run++;
      if (ax !== 7'(exp_p.x) || ay !== 6'(exp_p.y)) begin
        tests_failed++;
        $display("FAIL bounce_y_edge%0d: got (%0d,%0d) expected (%0d,%0d)",
                 edges, ax, ay, exp_p.x, exp_p.y);
      end
      if (edges == 4 * 63 || edges == 4 * 64) begin
        tests_run++;
        if ((edges == 4 * 63 && (ax !== 7'd63 || ay !== 6'd63)) ||
            (edges == 4 * 64 && (ax !== 7'd64 || ay !== 6'd62))) begin
          tests_failed++;
          $display("FAIL y_max_bounce_tick%0d: got (%0d,%0d)", edges / 4, ax, ay);
        end
      end
    end
  endtask

  task automatic test_bounce_x();
    while (edges < 4 * 127) begin
      sb.push_back('{tri_pos((edges + 1) / 4, 95), tri_pos((edges + 1) / 4, 63)});
      advance();
      exp_p = sb.pop_front();
      tests_run++;
      if (ax !== 7'(exp_p.x) || ay !== 6'(exp_p.y)) begin
        tests_failed++;
        $display("FAIL bounce_x_edge%0d: got (%0d,%0d) expected (%0d,%0d)",
                 edges, ax, ay, exp_p.x, exp_p.y);
      end
      if (edges == 4 * 95 || edges == 4 * 96 || edges == 4 * 126 || edges == 4 * 127) begin
        tests_run++;
        if ((edges == 4 * 95  && (ax !== 7'd95 || ay !== 6'd31)) ||
            (edges == 4 * 96  && (ax !== 7'd94 || ay !== 6'd30)) ||
            (edges == 4 * 126 && (ax !== 7'd64 || ay !== 6'd0))  ||
            (edges == 4 * 127 && (ax !== 7'd63 || ay !== 6'd1))) begin
          tests_failed++;
          $display("FAIL x_max_y_zero_tick%0d: got (%0d,%0d)", edges / 4, ax, ay);
        end
      end
    end
  endtask

  task automatic test_corner();
    pulse_reset();
    for (int e = 1; e <= 16; e++) begin
      sb.push_back('{tri_pos(e, 7), tri_pos(e, 7)});
      advance();
      exp_p = sb.pop_front();
      tests_run++;
      if (bx !== 7'(exp_p.x) || by !== 6'(exp_p.y)) begin
        tests_failed++;
        $display("FAIL corner_tick%0d: got (%0d,%0d) expected (%0d,%0d)",
                 e, bx, by, exp_p.x, exp_p.y);
      end
      if (e == 7 || e == 8 || e == 14 || e == 15) begin
        tests_run++;
        if ((e == 7  && (bx !== 7'd7 || by !== 6'd7)) ||
            (e == 8  && (bx !== 7'd6 || by !== 6'd6)) ||
            (e == 14 && (bx !== 7'd0 || by !== 6'd0)) ||
            (e == 15 && (bx !== 7'd1 || by !== 6'd1))) begin
          tests_failed++;
          $display("FAIL corner_fixed_tick%0d: got (%0d,%0d)", e, bx, by);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    while (edges < 42) advance();
    tests_run++;
    if (ax !== 7'd10 || ay !== 6'd10) begin
      tests_failed++;
      $display("FAIL pre_reset_pos: got (%0d,%0d) expected (10,10)", ax, ay);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (ax !== 7'd0 || ay !== 6'd0) begin
      tests_failed++;
      $display("FAIL async_reset_mid: got (%0d,%0d) expected (0,0)", ax, ay);
    end
    #2 rst_n = 1'b1;
    edges = 0;
    for (int e = 1; e <= 5; e++) begin
      sb.push_back('{(e >= 4) ? 1 : 0, (e >= 4) ? 1 : 0});
      advance();
      exp_p = sb.pop_front();
      tests_run++;
      if (ax !== 7'(exp_p.x) || ay !== 6'(exp_p.y)) begin
        tests_failed++;
        $display("FAIL after_async_reset_edge%0d: got (%0d,%0d) expected (%0d,%0d)",
                 e, ax, ay, exp_p.x, exp_p.y);
      end
    end
  endtask

  task automatic test_long_divider();
    pulse_reset();
    while (edges < LONG_DIV + 1) begin
      sb.push_back('{tri_pos((edges + 1) / LONG_DIV, 95), tri_pos((edges + 1) / LONG_DIV, 63)});
      advance();
      exp_p = sb.pop_front();
      tests_run++;
      if (cx !== 7'(exp_p.x) || cy !== 6'(exp_p.y)) begin
        tests_failed++;
        $display("FAIL long_div_edge%0d: got (%0d,%0d) expected (%0d,%0d)",
                 edges, cx, cy, exp_p.x, exp_p.y);
      end
      if (edges == LONG_DIV - 1 || edges == LONG_DIV) begin
        tests_run++;
        if ((edges == LONG_DIV - 1 && (cx !== 7'd0 || cy !== 6'd0)) ||
            (edges == LONG_DIV     && (cx !== 7'd1 || cy !== 6'd1))) begin
          tests_failed++;
          $display("FAIL long_div_boundary_edge%0d: got (%0d,%0d)", edges, cx, cy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce_y();
    test_bounce_x();
    test_corner();
    test_async_reset();
    test_long_divider();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
